// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath defaults, the canonical NOP and the
// IF/ID pipeline record.
package riscv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [31:0]             instr;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pcplus4;
    logic                    valid;
  } ifid_t;

  localparam ifid_t IFID_RESET = '{instr: NOP_INSTR, pc: '0, pcplus4: '0, valid: 1'b0};

  // A squashed slot keeps its PC fields so downstream debug still sees where it came from.
  function automatic ifid_t ifidBubble(input ifid_t cur);
    ifid_t b;
    b       = cur;
    b.instr = NOP_INSTR;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: clear (bubble insert) beats enable, enable low holds.
module ifid_reg
  import riscv_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  clr,
  input  ifid_t d,
  output ifid_t q
);

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= IFID_RESET;
    else if (clr) q <= ifidBubble(q);
    else if (en)  q <= d;
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch-stage PC register plus IF/ID register with EX-stage redirect and hazard stalls.
// Optional perf counters (RedirectCount, StallCount) when FETCH_PERF_CNT_EN is defined.
module fetch_redirect_unit
  import riscv_pkg::*;
#(
  parameter int             XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            NeedBranchE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [31:0]     InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FlushE,
  output logic            MisalignedF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] RedirectCount,
  output logic [XLEN-1:0] StallCount
`endif
);

  logic [XLEN-1:0] pcPlus4F;
  logic [XLEN-1:0] pcNext;
  logic [XLEN-1:0] alignedTarget;
  ifid_t           ifidD;
  ifid_t           ifidQ;

  assign pcPlus4F      = PCF + XLEN'(4);
  assign alignedTarget = {PCTargetE[XLEN-1:2], 2'b00};
  assign FlushE        = NeedBranchE;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pcNext = pcPlus4F;
    if (NeedBranchE) pcNext = alignedTarget;
    else if (StallF) pcNext = PCF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) PCF <= RESET_PC;
    else       PCF <= pcNext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        MisalignedF <= 1'b0;
    else if (NeedBranchE && (PCTargetE[1:0] != 2'b00)) MisalignedF <= 1'b1;
  end

  // The IF/ID record is sized by XLEN_DEFAULT; the core only builds with XLEN == 32.
  assign ifidD = '{instr: InstrF, pc: PCF, pcplus4: pcPlus4F, valid: 1'b1};

  ifid_reg u_ifid (
    .clk  (clk),
    .reset(reset),
    .en   (!StallD),
    .clr  (NeedBranchE),
    .d    (ifidD),
    .q    (ifidQ)
  );

  assign InstrD   = ifidQ.instr;
  assign PCD      = ifidQ.pc;
  assign PCPlus4D = ifidQ.pcplus4;
  assign ValidD   = ifidQ.valid;

`ifdef FETCH_PERF_CNT_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RedirectCount <= '0;
      StallCount    <= '0;
    end else begin
      if (NeedBranchE && (RedirectCount != '1))
        RedirectCount <= RedirectCount + XLEN'(1);
      if (StallF && !NeedBranchE && (StallCount != '1))
        StallCount <= StallCount + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: vector table for the main flow plus
// hand sequences for reset-during-redirect and the optional perf counters.
module tb_fetch_redirect_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RPC  = 32'h0000_1000;
  localparam logic [31:0] IKEY = 32'h5A00_0003;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, NeedBranchE;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD, FlushE, MisalignedF;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] RedirectCount, StallCount;
`endif

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  // Instruction memory model: each word is a recognisable function of its address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ IKEY;
  endfunction

  assign InstrF = imem(PCF);

  fetch_redirect_unit #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .NeedBranchE(NeedBranchE),
    .PCTargetE  (PCTargetE),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FlushE     (FlushE),
    .MisalignedF(MisalignedF)
`ifdef FETCH_PERF_CNT_EN
    ,
    .RedirectCount(RedirectCount),
    .StallCount   (StallCount)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sF, sD, br;
    logic [31:0] tgt;
    logic [31:0] pcF, instrD, pcD, pcP4D;
    logic        validD, mis;
  } vec_t;

  function automatic vec_t mk(input logic sF, input logic sD, input logic br,
                              input logic [31:0] tgt, input logic [31:0] pcF,
                              input logic [31:0] instrD, input logic [31:0] pcD,
                              input logic [31:0] pcP4D, input logic validD, input logic mis);
    vec_t v;
    v = '{sF, sD, br, tgt, pcF, instrD, pcD, pcP4D, validD, mis};
    return v;
  endfunction

  vec_t vecs[23];

  task automatic drive(input logic sF, input logic sD, input logic br, input logic [31:0] tgt);
    StallF      = sF;
    StallD      = sD;
    NeedBranchE = br;
    PCTargetE   = tgt;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected state after each edge, starting from PCF = 0x1000 with an empty decode slot.
    vecs[0]  = mk(0,0,0,32'h0,        32'h1004,     imem(32'h1000), 32'h1000, 32'h1004, 1, 0);
    vecs[1]  = mk(0,0,0,32'h0,        32'h1008,     imem(32'h1004), 32'h1004, 32'h1008, 1, 0);
    vecs[2]  = mk(0,0,0,32'h0,        32'h100C,     imem(32'h1008), 32'h1008, 32'h100C, 1, 0);
    vecs[3]  = mk(0,0,0,32'h0,        32'h1010,     imem(32'h100C), 32'h100C, 32'h1010, 1, 0);
    vecs[4]  = mk(0,0,1,32'h200,      32'h200,      NOP,            32'h100C, 32'h1010, 0, 0);
    vecs[5]  = mk(0,0,0,32'h0,        32'h204,      imem(32'h200),  32'h200,  32'h204,  1, 0);
    vecs[6]  = mk(0,0,1,32'h28,       32'h28,       NOP,            32'h200,  32'h204,  0, 0);
    vecs[7]  = mk(0,0,0,32'h0,        32'h2C,       imem(32'h28),   32'h28,   32'h2C,   1, 0);
    vecs[8]  = mk(1,1,0,32'h0,        32'h2C,       imem(32'h28),   32'h28,   32'h2C,   1, 0);
    vecs[9]  = mk(1,1,0,32'h0,        32'h2C,       imem(32'h28),   32'h28,   32'h2C,   1, 0);
    vecs[10] = mk(1,1,0,32'h0,        32'h2C,       imem(32'h28),   32'h28,   32'h2C,   1, 0);
    vecs[11] = mk(0,0,0,32'h0,        32'h30,       imem(32'h2C),   32'h2C,   32'h30,   1, 0);
    vecs[12] = mk(1,1,1,32'h80,       32'h80,       NOP,            32'h2C,   32'h30,   0, 0);
    vecs[13] = mk(0,0,0,32'h0,        32'h84,       imem(32'h80),   32'h80,   32'h84,   1, 0);
    vecs[14] = mk(0,0,1,32'h106,      32'h104,      NOP,            32'h80,   32'h84,   0, 1);
    vecs[15] = mk(0,0,0,32'h0,        32'h108,      imem(32'h104),  32'h104,  32'h108,  1, 1);
    vecs[16] = mk(1,0,0,32'h0,        32'h108,      imem(32'h108),  32'h108,  32'h10C,  1, 1);
    vecs[17] = mk(0,1,0,32'h0,        32'h10C,      imem(32'h108),  32'h108,  32'h10C,  1, 1);
    vecs[18] = mk(0,0,1,32'hFFFFFFFC, 32'hFFFFFFFC, NOP,            32'h108,  32'h10C,  0, 1);
    vecs[19] = mk(0,0,0,32'h0,        32'h0,        imem(32'hFFFFFFFC), 32'hFFFFFFFC, 32'h0, 1, 1);
    vecs[20] = mk(0,0,1,32'h300,      32'h300,      NOP,            32'hFFFFFFFC, 32'h0, 0, 1);
    vecs[21] = mk(0,0,1,32'h400,      32'h400,      NOP,            32'hFFFFFFFC, 32'h0, 0, 1);
    vecs[22] = mk(0,0,0,32'h0,        32'h404,      imem(32'h400),  32'h400,  32'h404,  1, 1);

    reset = 1'b1;
    drive(0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_pcf",    PCF,         RPC);
    check("rst_instrd", InstrD,      NOP);
    check("rst_pcd",    PCD,         32'h0);
    check("rst_pcp4d",  PCPlus4D,    32'h0);
    check("rst_validd", {31'b0, ValidD},      32'h0);
    check("rst_mis",    {31'b0, MisalignedF}, 32'h0);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].sF, vecs[i].sD, vecs[i].br, vecs[i].tgt);
      #1;
      check($sformatf("v%0d_flushe", i), {31'b0, FlushE}, {31'b0, vecs[i].br});
      stepEdge();
      check($sformatf("v%0d_pcf", i),    PCF,      vecs[i].pcF);
      check($sformatf("v%0d_instrd", i), InstrD,   vecs[i].instrD);
      check($sformatf("v%0d_pcd", i),    PCD,      vecs[i].pcD);
      check($sformatf("v%0d_pcp4d", i),  PCPlus4D, vecs[i].pcP4D);
      check($sformatf("v%0d_validd", i), {31'b0, ValidD},      {31'b0, vecs[i].validD});
      check($sformatf("v%0d_mis", i),    {31'b0, MisalignedF}, {31'b0, vecs[i].mis});
    end

    // Reset lands while a redirect is being requested: reset values win, nothing is remembered.
    drive(0, 0, 1, 32'h502);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_flushe", {31'b0, FlushE}, 32'h1);
    check("midrst_pcf",    PCF,    RPC);
    check("midrst_instrd", InstrD, NOP);
    check("midrst_mis",    {31'b0, MisalignedF}, 32'h0);
    stepEdge();
    check("midrst_pcf_edge", PCF, RPC);
    drive(0, 0, 0, 32'h0);
    reset = 1'b0;
    #1;
    check("postrst_pcf",    PCF, RPC);
    check("postrst_validd", {31'b0, ValidD}, 32'h0);
    stepEdge();
    check("postrst1_pcf",    PCF, RPC + 32'h4);
    check("postrst1_pcd",    PCD, RPC);
    check("postrst1_validd", {31'b0, ValidD}, 32'h1);
    check("postrst1_mis",    {31'b0, MisalignedF}, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("perf_rst_redir", RedirectCount, 32'h0);
    check("perf_rst_stall", StallCount,    32'h0);
    for (int i = 0; i < 5; i++) begin
      // The last redirect also has StallF high; it must not count as a stall cycle.
      drive((i == 4), 0, 1, 32'h600 + 32'(i * 16));
      stepEdge();
    end
    for (int i = 0; i < 7; i++) begin
      drive(1, (i % 2 == 0), 0, 32'h0);
      stepEdge();
    end
    drive(0, 0, 0, 32'h0);
    check("perf_redir_5", RedirectCount, 32'd5);
    check("perf_stall_7", StallCount,    32'd7);
    force dut.RedirectCount = 32'hFFFF_FFFF;
    #1;
    release dut.RedirectCount;
    drive(0, 0, 1, 32'h700);
    stepEdge();
    drive(0, 0, 0, 32'h0);
    check("perf_redir_sat", RedirectCount, 32'hFFFF_FFFF);
    check("perf_stall_keep", StallCount,   32'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
